// File: rtl/vram_arbiter.sv
// ============================================================================
//  Module      : vram_arbiter
//  Description : Single-port VRAM arbiter between a renderer and an MPU.
//                One access per clock, fixed renderer priority, registered
//                VRAM strobes and one-cycle grant pulses. Read data returns
//                one cycle after the grant together with an rvalid pulse.
//  Ports       : clk, reset           - clock, async active-high reset
//                ren_* / mpu_*        - requester ports (req, wr, be, addr,
//                                       wdata in; gnt, rdata, rvalid out)
//                vram_*               - VRAM strobes, be, addr, write data,
//                                       read data in
//  Options     : VRAM_ARB_STARVE_GUARD_EN - when defined, the MPU is forced
//                in after MAX_REN_BURST renderer grants taken while it waits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_REN_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ren_req,
  input  logic                  ren_wr,
  input  logic [1:0]            ren_be,
  input  logic [ADDR_WIDTH-1:0] ren_addr,
  input  logic [DATA_WIDTH-1:0] ren_wdata,
  output logic                  ren_gnt,
  output logic [DATA_WIDTH-1:0] ren_rdata,
  output logic                  ren_rvalid,
  input  logic                  mpu_req,
  input  logic                  mpu_wr,
  input  logic [1:0]            mpu_be,
  input  logic [ADDR_WIDTH-1:0] mpu_addr,
  input  logic [DATA_WIDTH-1:0] mpu_wdata,
  output logic                  mpu_gnt,
  output logic [DATA_WIDTH-1:0] mpu_rdata,
  output logic                  mpu_rvalid,
  output logic                  vram_en,
  output logic                  vram_rd,
  output logic                  vram_wr,
  output logic [1:0]            vram_be,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0] vram_data_out,
  input  logic [DATA_WIDTH-1:0] vram_data_in
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REN  = 2'd1,
    S_MPU  = 2'd2
  } state_t;

  state_t r_state;
  // Cleared by reset, set at the first edge afterwards: keeps the first edge
  // after release free of grants so arbitration restarts from a clean cycle.
  logic   r_armed;
  logic   w_mpu_force;
  logic   w_ren_win;
  logic   w_mpu_win;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_REN_BURST + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_mpu_force = mpu_req && (r_starve_cnt == CNT_W'(MAX_REN_BURST));

  // Counts renderer grants taken while the MPU is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!mpu_req || w_mpu_win) begin
      r_starve_cnt <= '0;
    end else if (w_ren_win) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_mpu_force = 1'b0;
`endif

  assign w_ren_win = r_armed && ren_req && !w_mpu_force;
  assign w_mpu_win = r_armed && mpu_req && !w_ren_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_armed       <= 1'b0;
      ren_gnt       <= 1'b0;
      ren_rdata     <= '0;
      ren_rvalid    <= 1'b0;
      mpu_gnt       <= 1'b0;
      mpu_rdata     <= '0;
      mpu_rvalid    <= 1'b0;
      vram_en       <= 1'b0;
      vram_rd       <= 1'b0;
      vram_wr       <= 1'b0;
      vram_be       <= '0;
      vram_addr     <= '0;
      vram_data_out <= '0;
    end else begin
      r_armed <= 1'b1;

      // The edge that ends a read cycle captures VRAM data for its owner.
      ren_rvalid <= (r_state == S_REN) && vram_rd;
      mpu_rvalid <= (r_state == S_MPU) && vram_rd;
      if ((r_state == S_REN) && vram_rd) ren_rdata <= vram_data_in;
      if ((r_state == S_MPU) && vram_rd) mpu_rdata <= vram_data_in;

      if (w_ren_win) begin
        r_state       <= S_REN;
        ren_gnt       <= 1'b1;
        mpu_gnt       <= 1'b0;
        vram_en       <= 1'b1;
        vram_wr       <= ren_wr;
        vram_rd       <= !ren_wr;
        vram_be       <= ren_be;
        vram_addr     <= ren_addr;
        vram_data_out <= ren_wr ? ren_wdata : '0;
      end else if (w_mpu_win) begin
        r_state       <= S_MPU;
        ren_gnt       <= 1'b0;
        mpu_gnt       <= 1'b1;
        vram_en       <= 1'b1;
        vram_wr       <= mpu_wr;
        vram_rd       <= !mpu_wr;
        vram_be       <= mpu_be;
        vram_addr     <= mpu_addr;
        vram_data_out <= mpu_wr ? mpu_wdata : '0;
      end else begin
        // Address deliberately holds its last value while idle.
        r_state       <= S_IDLE;
        ren_gnt       <= 1'b0;
        mpu_gnt       <= 1'b0;
        vram_en       <= 1'b0;
        vram_wr       <= 1'b0;
        vram_rd       <= 1'b0;
        vram_be       <= '0;
        vram_data_out <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
//  Module      : tb_vram_arbiter
//  Description : Self-checking bench for vram_arbiter. Tests push expected
//                grants/read returns into scoreboard queues; a negedge
//                monitor pops and compares them against DUT activity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ren_req, ren_wr, mpu_req, mpu_wr;
  logic [1:0]  ren_be, mpu_be;
  logic [15:0] ren_addr, ren_wdata, mpu_addr, mpu_wdata;
  logic        ren_gnt, ren_rvalid, mpu_gnt, mpu_rvalid;
  logic [15:0] ren_rdata, mpu_rdata;
  logic        vram_en, vram_rd, vram_wr;
  logic [1:0]  vram_be;
  logic [15:0] vram_addr, vram_data_out, vram_data_in;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_REN_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .ren_req(ren_req), .ren_wr(ren_wr), .ren_be(ren_be), .ren_addr(ren_addr),
    .ren_wdata(ren_wdata), .ren_gnt(ren_gnt), .ren_rdata(ren_rdata),
    .ren_rvalid(ren_rvalid),
    .mpu_req(mpu_req), .mpu_wr(mpu_wr), .mpu_be(mpu_be), .mpu_addr(mpu_addr),
    .mpu_wdata(mpu_wdata), .mpu_gnt(mpu_gnt), .mpu_rdata(mpu_rdata),
    .mpu_rvalid(mpu_rvalid),
    .vram_en(vram_en), .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_be(vram_be),
    .vram_addr(vram_addr), .vram_data_out(vram_data_out),
    .vram_data_in(vram_data_in)
  );

  // Small VRAM model indexed by the low address byte.
  logic [15:0] mem [0:255];
  assign vram_data_in = mem[vram_addr[7:0]];
  always @(posedge clk) begin
    if (vram_wr) begin
      if (vram_be[0]) mem[vram_addr[7:0]][7:0]  <= vram_data_out[7:0];
      if (vram_be[1]) mem[vram_addr[7:0]][15:8] <= vram_data_out[15:8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        owner;  // 0 = renderer, 1 = MPU
    logic        wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
  } gnt_t;
  typedef struct {
    logic        owner;
    logic [15:0] data;
  } rv_t;

  gnt_t q_gnt[$];
  rv_t  q_rv[$];
  int   cyc = 0;
  int   ren_gnt_cyc = 0;
  int   mpu_gnt_cyc = 0;
  logic [15:0] last_ren = 16'h0;
  logic [15:0] last_mpu = 16'h0;

  task automatic exp_acc(input logic owner, input logic wr, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata);
    gnt_t g;
    rv_t  r;
    g.owner = owner; g.wr = wr; g.be = be; g.addr = addr; g.wdata = wdata;
    q_gnt.push_back(g);
    if (!wr) begin
      r.owner = owner; r.data = rdata;
      q_rv.push_back(r);
    end
  endtask

  // Monitor / scoreboard comparator.
  gnt_t mg;
  rv_t  mr;
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (ren_gnt || mpu_gnt) begin
        if (ren_gnt) ren_gnt_cyc = cyc;
        if (mpu_gnt) mpu_gnt_cyc = cyc;
        if (q_gnt.size() == 0) begin
          chk("unexpected_gnt", {ren_gnt, mpu_gnt}, 64'h0);
        end else begin
          mg = q_gnt.pop_front();
          chk("gnt_bus",
              {ren_gnt, mpu_gnt, vram_en, vram_wr, vram_rd, vram_be, vram_addr, vram_data_out},
              {~mg.owner, mg.owner, 1'b1, mg.wr, ~mg.wr, mg.be, mg.addr,
               (mg.wr ? mg.wdata : 16'h0)});
        end
      end else begin
        chk("idle_bus", {vram_en, vram_rd, vram_wr, vram_be, vram_data_out}, 64'h0);
      end

      if (ren_rvalid || mpu_rvalid) begin
        if (q_rv.size() == 0) begin
          chk("unexpected_rvalid", {ren_rvalid, mpu_rvalid}, 64'h0);
        end else begin
          mr = q_rv.pop_front();
          chk("rvalid", {ren_rvalid, mpu_rvalid, (mr.owner ? mpu_rdata : ren_rdata)},
              {~mr.owner, mr.owner, mr.data});
          if (mr.owner) last_mpu = mr.data;
          else          last_ren = mr.data;
        end
      end
      if (!ren_rvalid) chk("ren_rdata_hold", ren_rdata, last_ren);
      if (!mpu_rvalid) chk("mpu_rdata_hold", mpu_rdata, last_mpu);
    end
  end

  task automatic wait_gnt(input logic mpu);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mpu ? mpu_gnt : ren_gnt) && n < 50);
    if (!(mpu ? mpu_gnt : ren_gnt)) chk("gnt_timeout", 64'h0, 64'h1);
  endtask

  task automatic ren_access(input logic wr, input logic [1:0] be,
                            input logic [15:0] addr, input logic [15:0] wdata);
    ren_req = 1'b1; ren_wr = wr; ren_be = be; ren_addr = addr; ren_wdata = wdata;
    wait_gnt(1'b0);
    #1 ren_req = 1'b0;
  endtask

  task automatic mpu_access(input logic wr, input logic [1:0] be,
                            input logic [15:0] addr, input logic [15:0] wdata);
    mpu_req = 1'b1; mpu_wr = wr; mpu_be = be; mpu_addr = addr; mpu_wdata = wdata;
    wait_gnt(1'b1);
    #1 mpu_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ren_req = 0; ren_wr = 0; ren_be = 0; ren_addr = 0; ren_wdata = 0;
    mpu_req = 0; mpu_wr = 0; mpu_be = 0; mpu_addr = 0; mpu_wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = {i[7:0], ~i[7:0]};
    mem[8'h34] = 16'hBEEF;
    mem[8'h30] = 16'hFFFF;

    repeat (3) @(negedge clk);
    chk("reset_ren_out", {ren_gnt, ren_rvalid, ren_rdata, mpu_gnt, mpu_rvalid, mpu_rdata}, 64'h0);
    chk("reset_vram_out", {vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out}, 64'h0);
    #1 reset = 1'b0;
    idle_cycles(2);

    // MPU read alone.
    exp_acc(1'b1, 1'b0, 2'b11, 16'h1234, 16'h0, 16'hBEEF);
    mpu_access(1'b0, 2'b11, 16'h1234, 16'h0);
    idle_cycles(3);

    // Collision: renderer byte-write wins, MPU follows with no idle cycle.
    exp_acc(1'b0, 1'b1, 2'b01, 16'h0030, 16'h1234, 16'h0);
    exp_acc(1'b1, 1'b0, 2'b11, 16'h0031, 16'h0, 16'h31CE);
    fork
      ren_access(1'b1, 2'b01, 16'h0030, 16'h1234);
      mpu_access(1'b0, 2'b11, 16'h0031, 16'h0);
    join
    chk("collision_b2b", mpu_gnt_cyc - ren_gnt_cyc, 64'd1);
    exp_acc(1'b1, 1'b0, 2'b11, 16'h0030, 16'h0, 16'hFF34);
    mpu_access(1'b0, 2'b11, 16'h0030, 16'h0);
    idle_cycles(3);

    // Interleave: renderer read then MPU write, back to back.
    exp_acc(1'b0, 1'b0, 2'b11, 16'h0010, 16'h0, 16'h10EF);
    exp_acc(1'b1, 1'b1, 2'b11, 16'h0020, 16'h5A5A, 16'h0);
    fork
      ren_access(1'b0, 2'b11, 16'h0010, 16'h0);
      mpu_access(1'b1, 2'b11, 16'h0020, 16'h5A5A);
    join
    chk("interleave_b2b", mpu_gnt_cyc - ren_gnt_cyc, 64'd1);
    exp_acc(1'b1, 1'b0, 2'b10, 16'h0020, 16'h0, 16'h5A5A);
    mpu_access(1'b0, 2'b10, 16'h0020, 16'h0);
    idle_cycles(3);

    // Starvation: both hold req; renderer for 20 edges.
    for (int i = 0; i < 20; i++) begin
`ifdef VRAM_ARB_STARVE_GUARD_EN
      if (i % 9 == 8) exp_acc(1'b1, 1'b0, 2'b11, 16'h0041, 16'h0, 16'h41BE);
      else            exp_acc(1'b0, 1'b0, 2'b11, 16'h0040, 16'h0, 16'h40BF);
`else
      exp_acc(1'b0, 1'b0, 2'b11, 16'h0040, 16'h0, 16'h40BF);
`endif
    end
    exp_acc(1'b1, 1'b0, 2'b11, 16'h0041, 16'h0, 16'h41BE);
    ren_req = 1'b1; ren_wr = 1'b0; ren_be = 2'b11; ren_addr = 16'h0040;
    mpu_req = 1'b1; mpu_wr = 1'b0; mpu_be = 2'b11; mpu_addr = 16'h0041;
    repeat (20) @(negedge clk);
    #1 ren_req = 1'b0;
    wait_gnt(1'b1);
    #1 mpu_req = 1'b0;
    idle_cycles(3);

    // Reset in the middle of a renderer read; the read must never return.
    ren_req = 1'b1; ren_wr = 1'b0; ren_be = 2'b11; ren_addr = 16'h0050;
    begin
      gnt_t g;
      g.owner = 1'b0; g.wr = 1'b0; g.be = 2'b11; g.addr = 16'h0050; g.wdata = 16'h0;
      q_gnt.push_back(g);
    end
    wait_gnt(1'b0);
    #1 reset = 1'b1;
    last_ren = 16'h0;
    last_mpu = 16'h0;
    #1;
    chk("rst_async_ren", {ren_gnt, ren_rvalid, ren_rdata, mpu_gnt, mpu_rvalid, mpu_rdata}, 64'h0);
    chk("rst_async_vram", {vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out}, 64'h0);
    exp_acc(1'b0, 1'b0, 2'b11, 16'h0050, 16'h0, 16'h50AF);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("no_gnt_first_edge", ren_gnt, 64'h0);
    wait_gnt(1'b0);
    #1 ren_req = 1'b0;
    idle_cycles(4);

    chk("gnt_queue_empty", q_gnt.size(), 64'h0);
    chk("rv_queue_empty", q_rv.size(), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
